// File: rtl/triangle_dispatcher.sv
// Round-robin dispatcher from the triangle FIFO to N_UNITS rasterizer units.
// Optional statistics counters are built when TRI_DISPATCH_STATS_EN is defined.
module triangle_dispatcher #(
  parameter int N_UNITS   = 4,
  parameter int TRI_WIDTH = 240
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dispatch_en,
  input  logic                 fifo_empty,
  input  logic [TRI_WIDTH-1:0] fifo_data,
  output logic                 fifo_pull,
  input  logic [N_UNITS-1:0]   unit_ready,
  output logic [N_UNITS-1:0]   tri_valid,
  output logic [TRI_WIDTH-1:0] tri_data,
  output logic                 drained,
  output logic [15:0]          stat_sent,
  output logic [15:0]          stat_stall
);

  localparam int IDX_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

  typedef enum logic [2:0] {IDLE, WAIT, LOAD, ARB, SEND} state_t;

  state_t           state;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_hit;
  logic             accept;

  // Search order starts one past the last grant and wraps through every unit.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int k = 1; k <= N_UNITS; k++) begin
      int j;
      j = (int'(last) + k) % N_UNITS;
      if (!arb_hit && (|(unit_ready & (N_UNITS'(1) << j)))) begin
        arb_hit = 1'b1;
        arb_idx = IDX_W'(j);
      end
    end
  end

  // Outputs are pure state decodes, so unit_ready never reaches tri_valid.
  assign tri_valid = (state == SEND) ? (N_UNITS'(1) << sel) : '0;
  assign fifo_pull = (state == LOAD);
  assign drained   = (state == IDLE) && fifo_empty;
  assign accept    = |(unit_ready & tri_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= IDX_W'(N_UNITS - 1);
      sel      <= '0;
      tri_data <= '0;
    end else begin
      case (state)
        IDLE: if (dispatch_en && !fifo_empty) state <= WAIT;
        WAIT: state <= LOAD;
        LOAD: begin
          tri_data <= fifo_data;
          state    <= ARB;
        end
        ARB: if (arb_hit) begin
          sel   <= arb_idx;
          last  <= arb_idx;
          state <= SEND;
        end
        SEND: if (accept) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TRI_DISPATCH_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_sent  <= '0;
      stat_stall <= '0;
    end else if (state == SEND) begin
      if (accept) stat_sent  <= sat_inc(stat_sent);
      else        stat_stall <= sat_inc(stat_stall);
    end
  end
`else
  assign stat_sent  = '0;
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_triangle_dispatcher.sv
// Directed bench for triangle_dispatcher with a one-cycle-latency FIFO model.
module tb_triangle_dispatcher;

  localparam int N = 4;
  localparam int W = 240;

  logic         clk = 1'b0;
  logic         rst;
  logic         dispatch_en;
  logic         fifo_empty;
  logic [W-1:0] fifo_data = '0;
  logic         fifo_pull;
  logic [N-1:0] unit_ready;
  logic [N-1:0] tri_valid;
  logic [W-1:0] tri_data;
  logic         drained;
  logic [15:0]  stat_sent;
  logic [15:0]  stat_stall;

  int checks = 0;
  int errors = 0;

  triangle_dispatcher #(.N_UNITS(N), .TRI_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .dispatch_en(dispatch_en), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_pull(fifo_pull), .unit_ready(unit_ready),
    .tri_valid(tri_valid), .tri_data(tri_data), .drained(drained),
    .stat_sent(stat_sent), .stat_stall(stat_stall)
  );

  always #5 clk = ~clk;

  // FIFO model: registered head read, pop on fifo_pull
  logic [W-1:0] mem [0:63];
  logic [5:0]   wr_ptr = '0;
  logic [5:0]   rd_ptr = '0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    fifo_data <= mem[rd_ptr];
    if (fifo_pull) rd_ptr <= rd_ptr + 6'd1;
  end

  // Transfer monitor
  int           cyc = 0;
  int           pull_cnt = 0;
  int           send_cnt = 0;
  int           ptq[$];
  int           gq[$];
  logic [W-1:0] dq[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_pull) begin
      pull_cnt <= pull_cnt + 1;
      ptq.push_back(cyc);
    end
    if (|(tri_valid & unit_ready)) begin
      send_cnt <= send_cnt + 1;
      for (int i = 0; i < N; i++) if (tri_valid[i]) gq.push_back(i);
      dq.push_back(tri_data);
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drained(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (drained) break;
    end
    check("drain_wait", drained, 1);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tri_valid != '0) break;
    end
    check("valid_wait", tri_valid != '0, 1);
  endtask

  logic [W-1:0] a5 = {30{8'hA5}};
  logic [W-1:0] hold;
  int bp, bg, bs;

  initial begin
    rst = 1'b1;
    dispatch_en = 1'b1;
    unit_ready = 4'b1111;
    @(negedge clk);
    do_reset();
    check("rst_valid", tri_valid, 0);
    check("rst_pull", fifo_pull, 0);
    check("rst_drained", drained, 1);
    check("rst_data", tri_data, 0);
    check("rst_sent", stat_sent, 0);
    check("rst_stall", stat_stall, 0);

    // Single triangle latency
    push(a5);
    @(negedge clk);
    check("c1_pull", fifo_pull, 0);
    check("c1_drained", drained, 0);
    @(negedge clk);
    check("c2_pull", fifo_pull, 1);
    @(negedge clk);
    check("c3_pull", fifo_pull, 0);
    check("c3_valid", tri_valid, 0);
    @(negedge clk);
    check("c4_valid", tri_valid, 4'b0001);
    check("c4_data", tri_data, a5);
    @(negedge clk);
    check("c5_drained", drained, 1);
    check("c5_valid", tri_valid, 0);

    // Eight back-to-back triangles, all units ready
    do_reset();
    bp = ptq.size(); bg = gq.size(); bs = pull_cnt;
    for (int i = 0; i < 8; i++) push({8{30'(i * 3 + 7)}});
    wait_drained(100);
    check("rr8_pulls", pull_cnt - bs, 8);
    for (int i = 0; i < 8; i++) begin
      check("rr8_grant", gq[bg + i], i % 4);
      check("rr8_data", dq[bg + i], {8{30'(i * 3 + 7)}});
    end
    for (int i = 1; i < 8; i++) check("rr8_period", ptq[bp + i] - ptq[bp + i - 1], 5);

    // Only unit 2 ready, then units 1 and 2
    do_reset();
    unit_ready = 4'b0100;
    bg = gq.size();
    for (int i = 0; i < 3; i++) push(240'(i + 100));
    wait_drained(60);
    for (int i = 0; i < 3; i++) check("u2_grant", gq[bg + i], 2);
    unit_ready = 4'b0110;
    push(240'h55);
    wait_drained(20);
    check("wrap_grant", gq[bg + 3], 1);

    // dispatch_en gating
    do_reset();
    unit_ready = 4'b1111;
    dispatch_en = 1'b0;
    bs = pull_cnt;
    for (int i = 0; i < 3; i++) push(240'(i + 200));
    repeat (6) @(negedge clk);
    check("en_off_pulls", pull_cnt - bs, 0);
    check("en_off_drained", drained, 0);
    dispatch_en = 1'b1;
    wait_drained(40);
    check("en_on_pulls", pull_cnt - bs, 3);
    bs = pull_cnt; bp = send_cnt;
    push(240'h301);
    push(240'h302);
    wait_valid();
    dispatch_en = 1'b0;
    repeat (8) @(negedge clk);
    check("drop_pulls", pull_cnt - bs, 1);
    check("drop_sends", send_cnt - bp, 1);
    check("drop_drained", drained, 0);
    dispatch_en = 1'b1;
    wait_drained(20);

    // Stalled offer held for ten cycles
    do_reset();
    unit_ready = 4'b0001;
    push(240'hBEEF);
    wait_valid();
    unit_ready = 4'b0000;
    hold = tri_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", tri_valid, 4'b0001);
      check("stall_data", tri_data, hold);
    end
    check("stall_data_val", hold, 240'hBEEF);
`ifdef TRI_DISPATCH_STATS_EN
    check("stat_stall", stat_stall, 10);
`else
    check("stat_stall", stat_stall, 0);
`endif
    unit_ready = 4'b0001;
    @(negedge clk);
    check("stall_done_valid", tri_valid, 0);
`ifdef TRI_DISPATCH_STATS_EN
    check("stat_sent", stat_sent, 1);
`else
    check("stat_sent", stat_sent, 0);
`endif

    // Reset during SEND drops the popped entry
    unit_ready = 4'b0001;
    push(240'hDEAD);
    wait_valid();
    unit_ready = 4'b0000;
    bs = pull_cnt; bp = send_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("rst_send_valid", tri_valid, 0);
    check("rst_send_pull", fifo_pull, 0);
    check("rst_send_drained", drained, 1);
    check("rst_send_stat", stat_stall, 0);
    rst = 1'b0;
    unit_ready = 4'b1111;
    repeat (6) @(negedge clk);
    check("rst_lost_pulls", pull_cnt - bs, 0);
    check("rst_lost_sends", send_cnt - bp, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/triangle_dispatcher.md
# triangle_dispatcher

Round-robin dispatcher between the triangle FIFO and a bank of N_UNITS rasterizer units. It waits for a head entry in the FIFO and absorbs the FIFO's one-cycle synchronous RAM read latency. It captures and pops the entry, then hands it to the next free unit with a valid/ready handshake. It also reports when the whole dispatch path has drained, for frame-end detection.

## Interface
- N_UNITS, 4, number of rasterizer units; legal range 1..8
- TRI_WIDTH, 240, triangle record width; must match the FIFO width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- dispatch_en  in  1  when low, no new triangle is fetched; an in-flight triangle still completes
- fifo_empty  in  1  FIFO empty flag
- fifo_data  in  TRI_WIDTH  FIFO read data; head entry, valid one cycle after the read pointer settles
- fifo_pull  out  1  one-cycle pop strobe to FIFO
- unit_ready  in  N_UNITS  per-unit "can accept a triangle"
- tri_valid  out  N_UNITS  one-hot offer to the selected unit
- tri_data  out  TRI_WIDTH  captured triangle record, shared by all units
- drained  out  1  high in IDLE when fifo_empty is high
- stat_sent  out  16  dispatched-triangle count (only with the macro)
- stat_stall  out  16  SEND cycles with the offer not yet accepted (only with the macro)

## Operation
- FSM: IDLE, WAIT, LOAD, ARB, SEND.
- IDLE → WAIT when dispatch_en && !fifo_empty; otherwise stay.
- WAIT → LOAD unconditionally; this cycle covers the FIFO read latency.
- LOAD: tri_data <= fifo_data; fifo_pull = 1 for exactly this cycle; → ARB.
- ARB: round-robin search of unit_ready, starting at last+1 mod N_UNITS.
  - Hit at index i: sel <= i, last <= i, → SEND.
  - No hit: stay in ARB.
- SEND: tri_valid = one-hot(sel). Transfer occurs when unit_ready[sel] is high; then → IDLE.
  - The offer stays committed to sel even if unit_ready[sel] drops; the block does not re-arbitrate.
- fifo_pull is asserted only in LOAD, so the FIFO never sees a pull while empty.
- dispatch_en is sampled only in IDLE. Dropping it in any later state does not abort the triangle.
- tri_data is held stable from LOAD until the next LOAD.
- Outside SEND, tri_valid = 0.
- drained = (state == IDLE) && fifo_empty, regardless of dispatch_en.
- Round-robin pointer wrap: last = N_UNITS-1 → search starts at 0.
- With N_UNITS = 1, ARB degenerates to waiting for unit_ready[0].

## Timing
- Reset values:
  - state = IDLE; last = N_UNITS-1, so the first grant goes to unit 0.
  - sel = 0, tri_data = 0, fifo_pull = 0, tri_valid = 0.
  - stat counters = 0.
  - drained follows fifo_empty from the first cycle after reset.
- Reset is synchronous, with priority over everything; reset mid-SEND drops the triangle.
- Latency, fifo_empty falling at cycle 0 with dispatch_en high and a unit ready:
  - WAIT at cycle 1, LOAD and fifo_pull at cycle 2.
  - ARB at cycle 3, tri_valid at cycle 4, accepted at cycle 4, IDLE at cycle 5.
- Minimum triangle period: 5 cycles.
- The pointer advances at the end of LOAD. The next head is read in the following WAIT (≥2 cycles later), so it is always valid.
- tri_valid and fifo_pull are registered or pure state decodes: no combinational path from unit_ready to tri_valid.

## Configuration
- TRI_DISPATCH_STATS_EN defined:
  - stat_sent increments on each SEND transfer.
  - stat_stall increments on each SEND cycle with !unit_ready[sel].
  - Both counters are 16 bits, saturate at 0xFFFF, and clear on rst.
- TRI_DISPATCH_STATS_EN undefined:
  - stat_sent and stat_stall are tied to 0.
  - No counter logic is built.

## Test plan
- Reset, then one triangle 0xA5..5 pushed with all units ready → fifo_pull at cycle 2, tri_valid = 4'b0001 at cycle 4, tri_data = 0xA5..5, drained high again at cycle 5.
- 8 triangles, all units always ready → grants 0,1,2,3,0,1,2,3; exactly 8 fifo_pull pulses, 5 cycles apart; data order preserved.
- unit_ready = 4'b0100 only → all triangles go to unit 2. Then raise unit 1 → after the last grant to 2, the next grant is unit 0/1 per wrap order (1 if only 1 and 2 are ready, starting from 3).
- dispatch_en low with FIFO holding 3 entries → no fifo_pull, drained low. Raise dispatch_en → 3 dispatches. Drop dispatch_en during SEND → current triangle completes, no further pulls.
- In SEND, hold unit_ready[sel] low for 10 cycles → tri_valid held, tri_data stable, stat_stall = 10 (macro on) or 0 (macro off), then accept → stat_sent = 1.
- Assert rst during SEND → next cycle tri_valid = 0, state IDLE, no fifo_pull, the FIFO entry already popped is lost.
